// File: rtl/genetic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : genetic_pkg
//  Description : Shared types and constants for the genetic-loop datapath.
//                Holds the mutator state enum, the gene width, the default
//                mutation threshold and the mutation-count width.
//  Ports       : none (package)
//  Revision    : 1.0  initial release
// ============================================================================
package genetic_pkg;

   localparam int               GENE_W            = 8;
   localparam logic [GENE_W-1:0] DEFAULT_THRESHOLD = 8'd16;
   localparam int               MUT_CNT_W         = 4;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ROLL_REQ  = 3'd1,
      S_ROLL_WAIT = 3'd2,
      S_VAL_REQ   = 3'd3,
      S_VAL_WAIT  = 3'd4,
      S_OUT       = 3'd5
   } state_e;

endpackage
`default_nettype wire

// File: rtl/rng_byte_requester.sv
`default_nettype none
// ============================================================================
//  Module      : rng_byte_requester
//  Description : Initiator side of the random-byte generator start/done
//                handshake. Turns a one-cycle request into a single
//                rng_start pulse and reports exactly one byte_valid event
//                when the matching rng_done returns.
//  Ports       : clk, rst          clock / synchronous active-high reset
//                req_i             request a byte (one cycle)
//                busy_o            a request is outstanding
//                byte_valid_o      requested byte arrived this cycle
//                byte_o            the arrived byte
//                rng_start_o       start pulse to the generator
//                rng_done_i        generator done pulse
//                rng_value_i       generator byte
//  Revision    : 1.0  initial release
// ============================================================================
module rng_byte_requester
   import genetic_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   output logic              busy_o,
   output logic              byte_valid_o,
   output logic [GENE_W-1:0] byte_o,
   output logic              rng_start_o,
   input  logic              rng_done_i,
   input  logic [GENE_W-1:0] rng_value_i
);

   logic busy_q;
   logic busy_d;

   // A start is only issued when nothing is outstanding, so two requests can
   // never overlap at the generator.
   assign rng_start_o  = req_i & ~busy_q;
   // Done pulses are only meaningful while we own an outstanding request;
   // this drops strays, including one left over from before a reset.
   assign byte_valid_o = busy_q & rng_done_i;
   assign byte_o       = rng_value_i;
   assign busy_o       = busy_q;

   always_comb begin
      busy_d = busy_q;
      if (rng_start_o) begin
         busy_d = 1'b1;
      end else if (byte_valid_o) begin
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/genome_mutator.sv
`default_nettype none
// ============================================================================
//  Module      : genome_mutator
//  Description : Walks the genes of a genome LSB-first, rolls one random
//                byte per gene and, when the roll is below THRESHOLD, XORs a
//                second random byte (LSB forced high) into that gene.
//                Emits the mutated genome and a saturating mutation count.
//  Ports       : clk, rst                    clock / sync active-high reset
//                in_valid/in_ready/in_genome  genome input handshake
//                out_valid/out_ready          result handshake
//                out_genome, out_mutations    result payload
//                rng_start/rng_done/rng_value random-byte generator port
//  Revision    : 1.0  initial release
// ============================================================================
module genome_mutator
   import genetic_pkg::*;
#(
   parameter int                GENE_BYTES = 4,
   parameter logic [GENE_W-1:0] THRESHOLD  = DEFAULT_THRESHOLD
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [GENE_W*GENE_BYTES-1:0] in_genome,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [GENE_W*GENE_BYTES-1:0] out_genome,
   output logic [MUT_CNT_W-1:0]         out_mutations,
   output logic                         rng_start,
   input  logic                         rng_done,
   input  logic [GENE_W-1:0]            rng_value
);

   localparam int                GW      = GENE_W * GENE_BYTES;
   localparam int                IDX_W   = (GENE_BYTES > 1) ? $clog2(GENE_BYTES) : 1;
   localparam logic [IDX_W-1:0]  C_LAST  = IDX_W'(GENE_BYTES - 1);
   // roll < THRESHOLD is evaluated as roll <= THRESHOLD-1, with a zero
   // threshold disabling mutation outright.
   localparam logic              C_THR_EN  = (THRESHOLD != '0);
   localparam logic [GENE_W-1:0] C_THR_MAX = C_THR_EN ? THRESHOLD - 8'd1 : '0;

   state_e               state_q, state_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [MUT_CNT_W-1:0] cnt_q, cnt_d;
   logic [GW-1:0]        work_q, work_d;

   logic                 req;
   logic                 busy;
   logic                 byte_valid;
   logic [GENE_W-1:0]    rnd_byte;
   logic                 roll_hit;
   logic [GW-1:0]        xor_mask;

   rng_byte_requester u_req (
      .clk          (clk),
      .rst          (rst),
      .req_i        (req),
      .busy_o       (busy),
      .byte_valid_o (byte_valid),
      .byte_o       (rnd_byte),
      .rng_start_o  (rng_start),
      .rng_done_i   (rng_done),
      .rng_value_i  (rng_value)
   );

   assign roll_hit = C_THR_EN && (rnd_byte <= C_THR_MAX);
   // Forcing the LSB guarantees a mutated gene really differs.
   assign xor_mask = GW'(rnd_byte | 8'h01) << (idx_q * GENE_W);

   assign in_ready      = (state_q == S_IDLE) & ~busy;
   assign out_valid     = (state_q == S_OUT);
   assign out_genome    = work_q;
   assign out_mutations = cnt_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      work_d  = work_q;
      req     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               work_d  = in_genome;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = S_ROLL_REQ;
            end
         end
         S_ROLL_REQ: begin
            req     = 1'b1;
            state_d = S_ROLL_WAIT;
         end
         S_ROLL_WAIT: begin
            if (byte_valid) begin
               if (roll_hit) begin
                  state_d = S_VAL_REQ;
               end else if (idx_q == C_LAST) begin
                  state_d = S_OUT;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_ROLL_REQ;
               end
            end
         end
         S_VAL_REQ: begin
            req     = 1'b1;
            state_d = S_VAL_WAIT;
         end
         S_VAL_WAIT: begin
            if (byte_valid) begin
               work_d = work_q ^ xor_mask;
               if (cnt_q != {MUT_CNT_W{1'b1}}) begin
                  cnt_d = cnt_q + 1'b1;
               end
               if (idx_q == C_LAST) begin
                  state_d = S_OUT;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = S_ROLL_REQ;
               end
            end
         end
         S_OUT: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         work_q  <= work_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_genome_mutator.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_genome_mutator
//  Description : Self-checking bench for genome_mutator. A behavioural
//                generator answers every start with done eight cycles later,
//                taking bytes from a scripted queue; expected genomes, counts
//                and latencies come from a gene-by-gene reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_genome_mutator;

   localparam int         GB  = 4;
   localparam logic [7:0] THR = 8'd16;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid, in_valid0;
   logic [31:0] in_genome;
   logic        in_ready, in_ready0;
   logic        out_valid, out_valid0;
   logic        out_ready, out_ready0;
   logic [31:0] out_genome, out_genome0;
   logic [3:0]  out_mutations, out_mutations0;
   logic        rng_start, rng_start0;
   logic        rng_done, rng_done0;
   logic [7:0]  rng_value, rng_value0;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          n_start = 0;
   int          n_start0 = 0;
   logic        spur;
   logic [7:0]  q  [$];
   logic [7:0]  bl [$];

   genome_mutator #(.GENE_BYTES(GB), .THRESHOLD(THR)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_genome(in_genome),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_genome(out_genome), .out_mutations(out_mutations),
      .rng_start(rng_start), .rng_done(rng_done), .rng_value(rng_value)
   );

   genome_mutator #(.GENE_BYTES(GB), .THRESHOLD(8'd0)) dut_t0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid0), .in_ready(in_ready0), .in_genome(in_genome),
      .out_valid(out_valid0), .out_ready(out_ready0),
      .out_genome(out_genome0), .out_mutations(out_mutations0),
      .rng_start(rng_start0), .rng_done(rng_done0), .rng_value(rng_value0)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Generator model for the main DUT: scripted bytes, 8-cycle latency.
   initial begin : gen_main
      int   pend;
      logic prev_start;
      rng_done = 1'b0; rng_value = 8'h00; pend = 0; prev_start = 1'b0;
      forever begin
         @(negedge clk);
         rng_done = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               rng_done  = 1'b1;
               rng_value = (q.size() > 0) ? q.pop_front() : 8'hFF;
            end
         end else if (spur) begin
            rng_done  = 1'b1;
            rng_value = 8'h00;
            spur      = 1'b0;
         end
         if (rng_start) begin
            n_start++;
            check_eq("start_gap", {31'd0, prev_start}, 32'd0);
            pend = 8;
         end
         prev_start = rng_start;
      end
   end

   // Generator model for the zero-threshold DUT: every byte is 8'h00.
   initial begin : gen_t0
      int pend;
      rng_done0 = 1'b0; rng_value0 = 8'h00; pend = 0;
      forever begin
         @(negedge clk);
         rng_done0 = 1'b0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) rng_done0 = 1'b1;
         end
         if (rng_start0) begin
            n_start0++;
            pend = 8;
         end
      end
   end

   // Gene-by-gene reference: consumes the byte list exactly as the
   // generator will deliver it.
   function automatic void ref_mutate(input logic [31:0] g, input logic [7:0] lst [$],
                                      output logic [31:0] og, output int muts, output int reqs);
      int k;
      k = 0; og = g; muts = 0; reqs = 0;
      for (int i = 0; i < GB; i++) begin
         logic [7:0] roll;
         roll = lst[k]; k++; reqs++;
         if (roll < THR) begin
            og[8*i +: 8] = og[8*i +: 8] ^ (lst[k] | 8'h01);
            k++; reqs++;
            if (muts < 15) muts++;
         end
      end
   endfunction

   task automatic send_main(input logic [31:0] g, output int lat);
      @(negedge clk);
      check_eq("in_ready_idle", {31'd0, in_ready}, 32'd1);
      in_genome = g;
      in_valid  = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      while (lat < 2000) begin
         @(negedge clk);
         if (out_valid) break;
         @(posedge clk);
         lat++;
      end
      lat = lat + 1;
      check_eq("out_valid_reached", {31'd0, out_valid}, 32'd1);
   endtask

   task automatic recv_main(input int hold);
      repeat (hold) @(negedge clk);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      check_eq("in_ready_after_out", {31'd0, in_ready}, 32'd1);
      check_eq("out_valid_after_out", {31'd0, out_valid}, 32'd0);
   endtask

   task automatic run_random(input int hold);
      logic [31:0] g, eg;
      logic [7:0]  roll;
      int          em, er, lat, s0;
      g  = $urandom;
      bl = {};
      for (int i = 0; i < GB; i++) begin
         roll = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
         bl.push_back(roll);
         if (roll < THR) bl.push_back(8'($urandom));
      end
      ref_mutate(g, bl, eg, em, er);
      q  = bl;
      s0 = n_start;
      send_main(g, lat);
      check_eq("rand_genome", out_genome, eg);
      check_eq("rand_mutations", {28'd0, out_mutations}, 32'(em));
      check_eq("rand_latency", 32'(lat), 32'(1 + 9 * er));
      check_eq("rand_starts", 32'(n_start - s0), 32'(er));
      recv_main(hold);
      q.delete();
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int          lat, s0, s1, w;
      logic [31:0] snap;
      rst = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0; in_genome = '0;
      out_ready = 1'b0; out_ready0 = 1'b1; spur = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_rng_start", {31'd0, rng_start}, 32'd0);
      check_eq("rst_out_genome", out_genome, 32'd0);
      check_eq("rst_out_mutations", {28'd0, out_mutations}, 32'd0);
      check_eq("rst_t0_in_ready", {31'd0, in_ready0}, 32'd1);

      // Zero threshold: genome passes through untouched.
      s0 = n_start0;
      @(negedge clk);
      in_genome = 32'hDEADBEEF; in_valid0 = 1'b1;
      @(posedge clk);
      #1 in_valid0 = 1'b0;
      lat = 0;
      while (lat < 2000) begin
         @(negedge clk);
         if (out_valid0) break;
         @(posedge clk);
         lat++;
      end
      lat = lat + 1;
      check_eq("t0_out_valid", {31'd0, out_valid0}, 32'd1);
      check_eq("t0_genome", out_genome0, 32'hDEADBEEF);
      check_eq("t0_mutations", {28'd0, out_mutations0}, 32'd0);
      check_eq("t0_latency", 32'(lat), 32'd37);
      check_eq("t0_starts", 32'(n_start0 - s0), 32'd4);
      @(negedge clk);
      check_eq("t0_in_ready_after", {31'd0, in_ready0}, 32'd1);

      // Scripted mutations on genes 0 and 2, then backpressure.
      q  = {8'h05, 8'hA0, 8'h40, 8'h0F, 8'h33, 8'hFF, 8'hFF};
      s0 = n_start;
      send_main(32'h0000_0000, lat);
      check_eq("scr_genome", out_genome, 32'h003300A1);
      check_eq("scr_mutations", {28'd0, out_mutations}, 32'd2);
      check_eq("scr_latency", 32'(lat), 32'd55);
      check_eq("scr_starts", 32'(n_start - s0), 32'd6);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) spur = 1'b1;
         @(negedge clk);
         check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
         check_eq("bp_genome", out_genome, 32'h003300A1);
         check_eq("bp_mutations", {28'd0, out_mutations}, 32'd2);
         check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
      end
      check_eq("bp_starts", 32'(n_start - s0), 32'd6);
      recv_main(0);
      q.delete();

      // Spurious done while idle.
      @(negedge clk);
      snap = out_genome;
      s0   = n_start;
      spur = 1'b1;
      repeat (4) @(negedge clk);
      check_eq("spur_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("spur_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("spur_genome", out_genome, snap);
      check_eq("spur_starts", 32'(n_start - s0), 32'd0);

      for (int t = 0; t < 12; t++) run_random($urandom_range(0, 3));

      // Reset while waiting on gene 1's roll.
      q.delete();
      repeat (20) q.push_back(8'hC8);
      s0 = n_start;
      @(negedge clk);
      in_genome = $urandom; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      w = 0;
      while (n_start < s0 + 2 && w < 100) begin
         @(negedge clk);
         w++;
      end
      check_eq("mid_rst_reached_gene1", 32'(n_start - s0), 32'd2);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      s1 = n_start;
      @(negedge clk);
      check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("mid_rst_rng_start", {31'd0, rng_start}, 32'd0);
      check_eq("mid_rst_genome", out_genome, 32'd0);
      check_eq("mid_rst_mutations", {28'd0, out_mutations}, 32'd0);
      repeat (10) @(negedge clk);
      check_eq("stale_starts", 32'(n_start - s1), 32'd0);
      check_eq("stale_in_ready", {31'd0, in_ready}, 32'd1);
      check_eq("stale_out_valid", {31'd0, out_valid}, 32'd0);
      q.delete();
      run_random(1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
